serial_chunk_adder: RTL and testbench
=====================================

SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4: bits added per cycle.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts operands.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A, unsigned or two's complement.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The block SHALL have port c_in, input, 1 bit: carry-in in add mode, borrow-in in subtract mode.
REQ-010 The block SHALL have port sub, input, 1 bit: 0 selects A+B+c_in; 1 selects A-B-c_in.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-014 The block SHALL have port c_out, output, 1 bit: final carry; in subtract mode 0 means borrow.
REQ-015 The block SHALL have port ovf, output, 1 bit: signed overflow.

Function
REQ-016 The block SHALL check at elaboration that WIDTH is divisible by CHUNK and that CHUNK >= 1; otherwise elaboration SHALL fail.
REQ-017 The block SHALL define NCH = WIDTH/CHUNK; the chunk counter SHALL be clog2(NCH) bits, minimum 1.
REQ-018 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-019 In IDLE, in_ready SHALL be 1; in_valid=1 SHALL capture the operands and move the FSM to RUN.
REQ-020 On capture, the block SHALL register a and register b if sub=0, or ~b if sub=1.
REQ-021 On capture, the carry register SHALL be loaded with c_in if sub=0, or ~c_in if sub=1.
REQ-022 On capture, the chunk index SHALL be cleared to 0.
REQ-023 In RUN, each cycle SHALL add chunk[idx] of A, chunk[idx] of B and the carry register.
REQ-024 Each RUN cycle SHALL write the chunk result into sum bits [idx*CHUNK +: CHUNK], update the carry register and increment idx.
REQ-025 On the last chunk (idx = NCH-1), the block SHALL set c_out to the chunk carry-out.
REQ-026 On the last chunk, the block SHALL set ovf to the carry into the MSB XOR the carry out of the MSB, then move to DONE.
REQ-027 The block SHALL have fixed latency: operands accepted at edge k SHALL give out_valid=1 after edge k+NCH.
REQ-028 In DONE, out_valid SHALL be 1 and in_ready SHALL be 0; sum, c_out and ovf SHALL be held stable.
REQ-029 In DONE with out_ready=1, the result SHALL be consumed and the FSM SHALL return to IDLE; the next operands SHALL be accepted no earlier than the following cycle.
REQ-030 With out_ready=0, DONE SHALL be held indefinitely, with no loss or change of the result.
REQ-031 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored.
REQ-032 Operand inputs SHALL be don't-care after capture; changes to them SHALL NOT affect the in-flight result.
REQ-033 For CHUNK = WIDTH, RUN SHALL last exactly one cycle.

Reset
REQ-034 While rst=1, the FSM SHALL be in IDLE, regardless of the current state.
REQ-035 While rst=1, sum, c_out, ovf and out_valid SHALL be 0, and in_ready SHALL be 1.
REQ-036 While rst=1, the operand registers, carry register and idx SHALL be 0.
REQ-037 Reset during RUN or DONE SHALL discard the operation with no partial output.
REQ-038 Operands SHALL be accepted from the first rising edge after rst deasserts.

Structure
REQ-039 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and a constant function for the counter width.
REQ-040 The block SHALL contain exactly one sub-module, add_chunk: a combinational CHUNK-bit ripple adder built from 1-bit full adders, with outputs sum, carry-out and the MSB carry-in.

Verification
REQ-041 With WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, c_in=0, sub=0 -> sum=0x0000, c_out=1, ovf=0, out_valid 4 cycles after accept.
REQ-042 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, c_out=0, ovf=1.
REQ-043 a=0x0005, b=0x0007, c_in=0, sub=1 -> sum=0xFFFE, c_out=0 (borrow), ovf=0; with c_in=1 -> sum=0xFFFD.
REQ-044 out_ready held 0 for 3 cycles in DONE -> result stable, in_ready=0 and in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-045 rst pulsed at RUN idx=2 -> all outputs 0 and in_ready=1 immediately; the next operation yields the correct sum.
REQ-046 CHUNK=16: a=0x1234, b=0x1111 -> sum=0x2345, out_valid 1 cycle after accept; back-to-back operations with out_ready=1 -> one result every 3 cycles.

Source files
------------

// File: rtl/serial_chunk_adder_pkg.sv
// Shared types for the serial chunk adder.
// Holds the FSM state enum and the chunk counter width helper.
package serial_chunk_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Counter width for nch chunks, never narrower than one bit.
  function automatic int cnt_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/serial_chunk_adder_add_chunk.sv
// add_chunk: combinational W-bit ripple adder of 1-bit full adders.
// Ports: a, b, ci in; s, co (carry out), c_msb (carry into MSB) out.
module add_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: adds/subtracts WIDTH-bit operands CHUNK bits per cycle.
// Ports: clk, rst, in_valid/in_ready + a,b,c_in,sub; out_valid/out_ready + sum,c_out,ovf.
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CH  = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCH = WIDTH / CH;
  localparam int IW  = cnt_width(NCH);
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);
  localparam logic [WIDTH-1:0] MASK = WIDTH'({CH{1'b1}});

  if (CHUNK < 1) begin : g_bad_chunk
    $error("serial_chunk_adder: CHUNK must be >= 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_div
    $error("serial_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [CH-1:0] a_ch;
  logic [CH-1:0] b_ch;
  logic [CH-1:0] s_ch;
  logic          co_ch;
  logic          cmsb_ch;
  int            sh;

  assign sh   = int'(idx_q) * CH;
  assign a_ch = CH'(a_q >> sh);
  assign b_ch = CH'(b_q >> sh);

  add_chunk #(
    .W(CH)
  ) u_add (
    .a    (a_ch),
    .b    (b_ch),
    .ci   (carry_q),
    .s    (s_ch),
    .co   (co_ch),
    .c_msb(cmsb_ch)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    sum_d       = sum_q;
    c_out_d     = c_out_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtract as A + ~B + ~c_in so c_out=0 signals a borrow.
          a_d        = a;
          b_d        = sub ? ~b : b;
          carry_d    = c_in ^ sub;
          idx_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~(MASK << sh)) |
                  (WIDTH'(s_ch) << sh);
        carry_d = co_ch;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          c_out_d     = co_ch;
          ovf_d       = cmsb_ch ^ co_ch;
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: a 4-bit-chunk and a single-chunk
// instance share stimulus and are checked against an arithmetic model.
module tb_serial_chunk_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic        sub;
  logic        out_ready;

  logic        in_ready4, out_valid4, c_out4, ovf4;
  logic [15:0] sum4;
  logic        in_ready16, out_valid16, c_out16, ovf16;
  logic [15:0] sum16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid4), .out_ready(out_ready),
    .sum(sum4), .c_out(c_out4), .ovf(ovf4)
  );

  serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready16),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid16), .out_ready(out_ready),
    .sum(sum16), .c_out(c_out16), .ovf(ovf16)
  );

  // Returns {ovf, c_out, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(
    input logic [15:0] x, input logic [15:0] y,
    input logic ci, input logic sb);
    int ur;
    int sr;
    int sx;
    int sy;
    logic co;
    logic ov;
    sx = $signed(x);
    sy = $signed(y);
    if (!sb) begin
      ur = int'(x) + int'(y) + int'(ci);
      sr = sx + sy + int'(ci);
      co = (ur > 65535);
    end else begin
      ur = int'(x) - int'(y) - int'(ci);
      sr = sx - sy - int'(ci);
      co = (ur >= 0);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, ur[15:0]};
  endfunction

  task automatic check_idle_zero(input string nm);
    total++;
    if ({in_ready4, out_valid4, c_out4, ovf4, sum4} !== {4'b1000, 16'h0}) begin
      bad++;
      $display("FAIL %s dut4: rdy=%b vld=%b co=%b ovf=%b sum=%h want 1 0 0 0 0000",
               nm, in_ready4, out_valid4, c_out4, ovf4, sum4);
    end
    total++;
    if ({in_ready16, out_valid16, c_out16, ovf16, sum16} !== {4'b1000, 16'h0}) begin
      bad++;
      $display("FAIL %s dut16: rdy=%b vld=%b co=%b ovf=%b sum=%h want 1 0 0 0 0000",
               nm, in_ready16, out_valid16, c_out16, ovf16, sum16);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_hold");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("after_reset");
  endtask

  task automatic do_op(input logic [15:0] xa, input logic [15:0] xb,
                       input logic ci, input logic sb, input string nm);
    logic [17:0] e;
    int lat4;
    int lat16;
    e = model(xa, xb, ci, sb);
    @(negedge clk);
    total++;
    if (in_ready4 !== 1'b1 || in_ready16 !== 1'b1) begin
      bad++;
      $display("FAIL %s ready: got %b/%b want 1/1", nm, in_ready4, in_ready16);
    end
    a = xa; b = xb; c_in = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat4 = 0;
    lat16 = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      // Scramble inputs in flight; they must be ignored.
      a = 16'($urandom); b = 16'($urandom);
      c_in = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (out_valid16 === 1'b1 && lat16 == 0) lat16 = cyc;
      if (out_valid4 === 1'b1) begin
        lat4 = cyc;
        break;
      end
    end
    in_valid = 1'b0;
    total++;
    if (lat4 != 4) begin
      bad++;
      $display("FAIL %s lat4: got %0d want 4", nm, lat4);
    end
    total++;
    if (lat16 != 1) begin
      bad++;
      $display("FAIL %s lat16: got %0d want 1", nm, lat16);
    end
    total++;
    if ({ovf4, c_out4, sum4} !== e) begin
      bad++;
      $display("FAIL %s res4: got ovf=%b co=%b sum=%h want ovf=%b co=%b sum=%h",
               nm, ovf4, c_out4, sum4, e[17], e[16], e[15:0]);
    end
    total++;
    if ({ovf16, c_out16, sum16} !== e) begin
      bad++;
      $display("FAIL %s res16: got ovf=%b co=%b sum=%h want ovf=%b co=%b sum=%h",
               nm, ovf16, c_out16, sum16, e[17], e[16], e[15:0]);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({in_ready4, out_valid4, in_ready16, out_valid16} !== 4'b1010) begin
      bad++;
      $display("FAIL %s consume: got rdy/vld %b%b %b%b want 10 10",
               nm, in_ready4, out_valid4, in_ready16, out_valid16);
    end
  endtask

  task automatic test_directed;
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "wrap");
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "pos_ovf");
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, "borrow");
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, "borrow_cin");
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, "neg_ovf");
    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, "plain");
  endtask

  task automatic test_random;
    for (int i = 0; i < 25; i++)
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand");
  endtask

  task automatic test_hold;
    logic [17:0] e;
    int n;
    e = model(16'hA5C3, 16'h3C5A, 1'b1, 1'b0);
    @(negedge clk);
    a = 16'hA5C3; b = 16'h3C5A; c_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (out_valid4 !== 1'b1 && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    total++;
    if (out_valid4 !== 1'b1) begin
      bad++;
      $display("FAIL hold_wait: out_valid never rose within 20 cycles");
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({out_valid4, in_ready4, ovf4, c_out4, sum4} !== {2'b10, e}) begin
        bad++;
        $display("FAIL hold_%0d: got vld=%b rdy=%b ovf=%b co=%b sum=%h want 1 0 %b %b %h",
                 k, out_valid4, in_ready4, ovf4, c_out4, sum4, e[17], e[16], e[15:0]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({in_ready4, out_valid4} !== 2'b10) begin
      bad++;
      $display("FAIL hold_release: got rdy=%b vld=%b want 1 0", in_ready4, out_valid4);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    a = 16'h5555; b = 16'h2222; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_idle_zero("reset_mid");
    @(negedge clk);
    rst = 1'b0;
    do_op(16'h5555, 16'h2222, 1'b0, 1'b0, "post_reset");
    do_op(16'($urandom), 16'($urandom), 1'b1, 1'b1, "post_reset_rand");
  endtask

  task automatic test_back_to_back;
    logic [17:0] e;
    int t4[$];
    int t16[$];
    @(negedge clk);
    a = 16'($urandom); b = 16'($urandom);
    c_in = 1'($urandom); sub = 1'($urandom);
    e = model(a, b, c_in, sub);
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid16 === 1'b1) begin
        t16.push_back(cyc);
        total++;
        if ({ovf16, c_out16, sum16} !== e) begin
          bad++;
          $display("FAIL b2b_res16 @%0d: got %h want %h", cyc,
                   {ovf16, c_out16, sum16}, e);
        end
      end
      if (out_valid4 === 1'b1) begin
        t4.push_back(cyc);
        total++;
        if ({ovf4, c_out4, sum4} !== e) begin
          bad++;
          $display("FAIL b2b_res4 @%0d: got %h want %h", cyc,
                   {ovf4, c_out4, sum4}, e);
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++;
    if (t16.size() < 8 || t4.size() < 4) begin
      bad++;
      $display("FAIL b2b_count: got %0d/%0d results want >=8/>=4",
               t16.size(), t4.size());
    end
    for (int i = 1; i < t16.size(); i++) begin
      total++;
      if (t16[i] - t16[i-1] != 3) begin
        bad++;
        $display("FAIL b2b_gap16: got %0d want 3", t16[i] - t16[i-1]);
      end
    end
    for (int i = 1; i < t4.size(); i++) begin
      total++;
      if (t4[i] - t4[i-1] != 6) begin
        bad++;
        $display("FAIL b2b_gap4: got %0d want 6", t4[i] - t4[i-1]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_hold;
    test_reset_mid;
    test_back_to_back;
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
